// File: rtl/threshold_seq.sv
// -----------------------------------------------------------------------------
// threshold_seq
//
// A sequential threshold logic gate. Each accepted request does the
// following:
//   - It sums the weights w[i] of all inputs where x_i = 1, one input per
//     cycle, into a signed accumulator of W+3 bits.
//   - It compares that sum against the threshold th. The decision is
//     f = (sum >= th), using a signed compare.
//   - It presents sum and f through a valid/ready output handshake.
//
// Weights and threshold are set through a small configuration write port.
// Reset loads weight 1 for every input and threshold 2.
//
// Optional feature, macro TLG_LEARN_EN:
//   Defining this macro adds an UPD state after the compare. When f differs
//   from the latched target in_t, UPD applies a saturating perceptron step to
//   the active weights and to the threshold. Without the macro, in_t is
//   ignored and neither UPD nor any weight-update logic exists.
//
// Parameters:
//   N : number of binary gate inputs (2..7)
//   W : signed width of each weight and of the threshold
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   cfg_we    : configuration write strobe (honoured only in IDLE)
//   cfg_addr  : 0..N-1 select weight w[i], N selects th, larger values ignored
//   cfg_data  : signed write value
//   in_valid  : evaluation request
//   in_ready  : block can accept a request (IDLE only)
//   in_x      : binary input vector, bit i = x_i
//   in_t      : training target (used only with TLG_LEARN_EN)
//   out_valid : result available
//   out_ready : consumer accepts result
//   out_f     : gate decision
//   out_sum   : signed weighted sum, W+3 bits
// -----------------------------------------------------------------------------
module threshold_seq #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cfg_we,
   input  logic [2:0]   cfg_addr,
   input  logic [W-1:0] cfg_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_x,
   input  logic         in_t,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_f,
   output logic [W+2:0] out_sum
);

   localparam int SW = W + 3;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

`ifdef TLG_LEARN_EN
   localparam logic signed [W-1:0] W_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] W_MIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, ACC, CMP, UPD, OUT} state_t;
`else
   typedef enum logic [2:0] {IDLE, ACC, CMP, OUT} state_t;
`endif

   state_t               state;
   state_t               next_state;
   logic                 ready_en;
   logic [N-1:0]         x_q;
   logic [IW-1:0]        idx;
   logic signed [SW-1:0] acc;
   logic signed [SW-1:0] sum_q;
   logic                 f_q;
   logic signed [W-1:0]  w [N];
   logic signed [W-1:0]  th;
   logic                 accept;
   logic                 cfg_ok;
   logic signed [SW-1:0] w_ext;
   logic signed [SW-1:0] th_ext;

`ifdef TLG_LEARN_EN
   logic                 t_q;

   // One saturating +/-1 step within the signed W-bit range.
   function automatic logic signed [W-1:0] sat_step(input logic signed [W-1:0] v,
                                                    input logic up);
      logic signed [W-1:0] r;
      r = v;
      if (up && (v != W_MAX)) begin
         r = v + W'(1);
      end else if (!up && (v != W_MIN)) begin
         r = v - W'(1);
      end
      return r;
   endfunction
`else
   logic                 unused_t;
   assign unused_t = in_t;
`endif

   // ready_en keeps in_ready low while reset is held. It also keeps in_ready
   // low until the first clock edge after reset is released.
   assign in_ready  = (state == IDLE) && ready_en;
   assign accept    = in_valid && in_ready;
   assign cfg_ok    = cfg_we && (state == IDLE);
   assign out_valid = (state == OUT);
   assign out_f     = f_q;
   assign out_sum   = sum_q;

   assign w_ext  = {{3{w[idx][W-1]}}, w[idx]};
   assign th_ext = {{3{th[W-1]}}, th};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ready_en <= 1'b0;
      end else begin
         state    <= next_state;
         ready_en <= 1'b1;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = ACC;
            end
         end
         ACC: begin
            if (idx == LAST_IDX) begin
               next_state = CMP;
            end
         end
         CMP: begin
`ifdef TLG_LEARN_EN
            next_state = UPD;
`else
            next_state = OUT;
`endif
         end
`ifdef TLG_LEARN_EN
         UPD: begin
            next_state = OUT;
         end
`endif
         OUT: begin
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Weight and threshold storage.
   // A configuration write lands on the accept edge. ACC reads the weights
   // only in later cycles, so a write in the accept cycle is already visible
   // to that evaluation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            w[i] <= W'(1);
         end
         th <= W'(2);
      end else begin
         if (cfg_ok) begin
            for (int i = 0; i < N; i++) begin
               if (cfg_addr == 3'(i)) begin
                  w[i] <= cfg_data;
               end
            end
            if (cfg_addr == 3'(N)) begin
               th <= cfg_data;
            end
         end
`ifdef TLG_LEARN_EN
         else if ((state == UPD) && (f_q != t_q)) begin
            for (int i = 0; i < N; i++) begin
               if (x_q[i]) begin
                  w[i] <= sat_step(w[i], t_q);
               end
            end
            th <= sat_step(th, !t_q);
         end
`endif
      end
   end

   // Evaluation datapath.
   // ACC visits one input per cycle. CMP captures the sum and decision into
   // the output registers, which stay stable through OUT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q   <= '0;
         idx   <= '0;
         acc   <= '0;
         sum_q <= '0;
         f_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  x_q <= in_x;
                  idx <= '0;
                  acc <= '0;
               end
            end
            ACC: begin
               if (x_q[idx]) begin
                  acc <= acc + w_ext;
               end
               idx <= idx + IW'(1);
            end
            CMP: begin
               f_q   <= (acc >= th_ext);
               sum_q <= acc;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef TLG_LEARN_EN
   // Latched training target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_q <= 1'b0;
      end else if (accept) begin
         t_q <= in_t;
      end
   end
`endif

endmodule
